// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the serial RAM boot loader.
//   loader_state_e : frame-parser FSM states
//   uart_state_e   : UART byte receiver states
//   HDR_BYTES      : number of header bytes preceding the payload
//   UART_IDLE      : idle (mark) level of the serial line
// Optional feature macro used by the loader: LOADER_CHECKSUM_EN
// ---------------------------------------------------------------------------
package loader_pkg;

  localparam int unsigned HDR_BYTES = 4;
  localparam logic        UART_IDLE = 1'b1;

  typedef enum logic [2:0] {
    HDR_AH,
    HDR_AL,
    HDR_LH,
    HDR_LL,
    DATA,
    WRITE,
    CHK,
    FIN
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
// 8N1 UART byte receiver working on an already-synchronised serial line.
// A falling edge on the idle line starts a frame; the start bit is re-checked
// at half a bit time, data bits are sampled mid-bit LSB first, and the stop
// bit is sampled mid-bit.
// Ports:
//   clk        : system clock (posedge)
//   reset      : synchronous active-high reset
//   rx_sync    : synchronised serial input, idles high
//   byte_out   : last good byte received
//   byte_valid : one-cycle pulse when byte_out is updated
//   frame_err  : one-cycle pulse when a stop bit reads 0 (byte dropped)
// ---------------------------------------------------------------------------
module uart_byte_rx
  import loader_pkg::*;
#(
  parameter int ClksPerBit = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_sync,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] HalfBit = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullBit = CntW'(ClksPerBit - 1);

  uart_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            rx_prev_q;

  // NOTE: all state here is updated with <= so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_prev_q  <= UART_IDLE;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_prev_q  <= rx_sync;
      case (state_q)
        RX_IDLE: begin
          // Start only on a true high->low edge, so a line still low after a
          // framing error does not immediately retrigger.
          if (rx_prev_q == UART_IDLE && rx_sync != UART_IDLE) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HalfBit) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= (rx_sync == UART_IDLE) ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FullBit) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= RX_STOP;
            else               bit_q   <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FullBit) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rx_sync == UART_IDLE) begin
              byte_out   <= shift_q;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ram_serial_loader.sv
// ---------------------------------------------------------------------------
// ram_serial_loader
// Serial boot loader driving a RAM write port. Parses a UART frame
// ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, payload[LEN] and writes each payload
// byte to consecutive RAM addresses (wrapping modulo 2^AddressSize).
// Optional feature macro: LOADER_CHECKSUM_EN -- a trailing byte holding the
// modulo-256 sum of the payload is checked; a mismatch sets err.
// Ports:
//   clk     : system clock (posedge)
//   reset   : synchronous active-high reset
//   rx      : UART serial input, idles high
//   Address : RAM address, held between writes
//   RamData : RAM write data, held between writes
//   CS, WE  : active-low chip select / write enable, low for one cycle/write
//   OE      : active-low output enable, tied inactive
//   busy    : high from the first header byte until frame completion
//   done    : one-cycle pulse on frame completion
//   err     : sticky framing/checksum error, cleared only by reset
// ---------------------------------------------------------------------------
module ram_serial_loader
  import loader_pkg::*;
#(
  parameter int AddressSize = 16,
  parameter int WordSize    = 8,
  parameter int ClksPerBit  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic [AddressSize-1:0] Address,
  output logic [WordSize-1:0]    RamData,
  output logic                   CS,
  output logic                   WE,
  output logic                   OE,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  logic       rx_meta_q, rx_sync_q;
  logic [7:0] rx_byte;
  logic       byte_valid, frame_err;

  loader_state_e          state_q;
  logic [7:0]             addr_hi_q;
  logic [7:0]             len_hi_q;
  logic [AddressSize-1:0] cur_addr_q;
  logic [15:0]            remaining_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum_q;
`endif

  // Two-flop synchroniser; resets to the idle level so no false start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= UART_IDLE;
      rx_sync_q <= UART_IDLE;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  uart_byte_rx #(
    .ClksPerBit(ClksPerBit)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_sync   (rx_sync_q),
    .byte_out  (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign OE = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR_AH;
      addr_hi_q   <= '0;
      len_hi_q    <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      Address     <= '0;
      RamData     <= '0;
      CS          <= 1'b1;
      WE          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      done <= 1'b0;
      // A bad byte never raises byte_valid, so the FSM simply waits for the
      // next good byte to fill the same field.
      if (frame_err) err <= 1'b1;

      case (state_q)
        HDR_AH: if (byte_valid) begin
          addr_hi_q <= rx_byte;
          busy      <= 1'b1;
          state_q   <= HDR_AL;
        end
        HDR_AL: if (byte_valid) begin
          cur_addr_q <= AddressSize'({addr_hi_q, rx_byte});
          state_q    <= HDR_LH;
        end
        HDR_LH: if (byte_valid) begin
          len_hi_q <= rx_byte;
          state_q  <= HDR_LL;
        end
        HDR_LL: if (byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
          csum_q <= '0;
`endif
          if ({len_hi_q, rx_byte} == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
            state_q <= CHK;
`else
            state_q <= FIN;
            done    <= 1'b1;
            busy    <= 1'b0;
`endif
          end else begin
            remaining_q <= {len_hi_q, rx_byte};
            state_q     <= DATA;
          end
        end
        DATA: if (byte_valid) begin
          RamData <= WordSize'(rx_byte);
          Address <= cur_addr_q;
          CS      <= 1'b0;
          WE      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
          csum_q  <= csum_q + rx_byte;
`endif
          state_q <= WRITE;
        end
        WRITE: begin
          // Exactly one cycle with CS/WE low: the RAM sees one write edge.
          CS          <= 1'b1;
          WE          <= 1'b1;
          cur_addr_q  <= cur_addr_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
          if (remaining_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_q <= CHK;
`else
            state_q <= FIN;
            done    <= 1'b1;
            busy    <= 1'b0;
`endif
          end else begin
            state_q <= DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (byte_valid) begin
          if (rx_byte != csum_q) err <= 1'b1;
          state_q <= FIN;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
`endif
        FIN:     state_q <= HDR_AH;
        default: state_q <= HDR_AH;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_serial_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_serial_loader
// Directed bench for ram_serial_loader with ClksPerBit=16. A behavioural RAM
// (async read, posedge write, active-low CS/WE) captures writes; monitors
// count write cycles, done pulses and any cycle where OE is not high.
// ---------------------------------------------------------------------------
module tb_ram_serial_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] Address;
  logic [7:0]  RamData;
  logic        CS, WE, OE, busy, done, err;

  int errors = 0;
  int checks = 0;

  ram_serial_loader #(
    .AddressSize(16),
    .WordSize   (8),
    .ClksPerBit (CPB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .Address(Address),
    .RamData(RamData),
    .CS     (CS),
    .WE     (WE),
    .OE     (OE),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // RAM model and activity monitors
  logic [7:0] mem [0:65535];
  int   we_cnt = 0, we_long = 0, done_cnt = 0, done_long = 0, oe_bad = 0;
  logic we_prev = 1'b0, done_prev = 1'b0;

  initial for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;

  always @(posedge clk) begin
    if (!CS && !WE) begin
      mem[Address] <= RamData;
      we_cnt <= we_cnt + 1;
      if (we_prev) we_long <= we_long + 1;
    end
    we_prev <= !CS && !WE;
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (done_prev) done_long <= done_long + 1;
    end
    done_prev <= done;
  end

  always @(negedge clk) if (OE !== 1'b1) oe_bad <= oe_bad + 1;

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
    send_byte(c, 1'b1);
`else
    if (c === 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic chk8(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk8("rst_CS", {15'd0, CS}, 16'd1);
    chk8("rst_WE", {15'd0, WE}, 16'd1);
    chk8("rst_OE", {15'd0, OE}, 16'd1);
    chk8("rst_Address", Address, 16'h0000);
    chk8("rst_RamData", {8'd0, RamData}, 16'h0000);
    chk8("rst_busy", {15'd0, busy}, 16'd0);
    chk8("rst_done", {15'd0, done}, 16'd0);
    chk8("rst_err", {15'd0, err}, 16'd0);
  endtask

  task automatic test_basic;
    int w0, d0, wl0, dl0;
    w0 = we_cnt; d0 = done_cnt; wl0 = we_long; dl0 = done_long;
    send_byte(8'h80, 1'b1);
    chk8("basic_busy_mid", {15'd0, busy}, 16'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    send_csum(8'h00);
    repeat (10) @(negedge clk);
    chk8("basic_mem8000", {8'd0, mem[16'h8000]}, 16'h00AA);
    chk8("basic_mem8001", {8'd0, mem[16'h8001]}, 16'h0055);
    chk8("basic_mem8002", {8'd0, mem[16'h8002]}, 16'h0001);
    chk8("basic_we_count", 16'(we_cnt - w0), 16'd3);
    chk8("basic_we_long", 16'(we_long - wl0), 16'd0);
    chk8("basic_done_count", 16'(done_cnt - d0), 16'd1);
    chk8("basic_done_long", 16'(done_long - dl0), 16'd0);
    chk8("basic_busy_after", {15'd0, busy}, 16'd0);
    chk8("basic_Address_hold", Address, 16'h8002);
    chk8("basic_RamData_hold", {8'd0, RamData}, 16'h0001);
    chk8("basic_CS_idle", {15'd0, CS}, 16'd1);
    chk8("basic_err", {15'd0, err}, 16'd0);
  endtask

  task automatic test_len_zero;
    int w0, d0;
    w0 = we_cnt; d0 = done_cnt;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_csum(8'h00);
    repeat (10) @(negedge clk);
    chk8("len0_done", 16'(done_cnt - d0), 16'd1);
    chk8("len0_no_we", 16'(we_cnt - w0), 16'd0);
    chk8("len0_mem1234", {8'd0, mem[16'h1234]}, 16'h00EE);
    chk8("len0_busy", {15'd0, busy}, 16'd0);
  endtask

  task automatic test_wrap;
    int w0;
    w0 = we_cnt;
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_csum(8'h33);
    repeat (10) @(negedge clk);
    chk8("wrap_memFFFF", {8'd0, mem[16'hFFFF]}, 16'h0011);
    chk8("wrap_mem0000", {8'd0, mem[16'h0000]}, 16'h0022);
    chk8("wrap_we_count", 16'(we_cnt - w0), 16'd2);
    chk8("wrap_Address", Address, 16'h0000);
  endtask

  task automatic test_frame_err;
    int w0, d0;
    w0 = we_cnt; d0 = done_cnt;
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);  // LEN_HI with a bad stop bit
    chk8("ferr_err_set", {15'd0, err}, 16'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_csum(8'h5A);
    repeat (10) @(negedge clk);
    chk8("ferr_err_sticky", {15'd0, err}, 16'd1);
    chk8("ferr_we_count", 16'(we_cnt - w0), 16'd1);
    chk8("ferr_mem2000", {8'd0, mem[16'h2000]}, 16'h005A);
    chk8("ferr_mem2001", {8'd0, mem[16'h2001]}, 16'h00EE);
    chk8("ferr_done", 16'(done_cnt - d0), 16'd1);
  endtask

  task automatic test_reset_mid;
    int w0, d0;
    w0 = we_cnt;
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h10, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk8("rmid_CS", {15'd0, CS}, 16'd1);
    chk8("rmid_WE", {15'd0, WE}, 16'd1);
    chk8("rmid_OE", {15'd0, OE}, 16'd1);
    chk8("rmid_Address", Address, 16'h0000);
    chk8("rmid_RamData", {8'd0, RamData}, 16'h0000);
    chk8("rmid_busy", {15'd0, busy}, 16'd0);
    chk8("rmid_done", {15'd0, done}, 16'd0);
    chk8("rmid_err", {15'd0, err}, 16'd0);
    repeat (200) @(negedge clk);
    chk8("rmid_we_count", 16'(we_cnt - w0), 16'd1);
    chk8("rmid_mem4000", {8'd0, mem[16'h4000]}, 16'h0010);
    chk8("rmid_mem4001", {8'd0, mem[16'h4001]}, 16'h00EE);
    d0 = done_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h77, 1'b1);
    send_csum(8'h77);
    repeat (10) @(negedge clk);
    chk8("rmid_mem0010", {8'd0, mem[16'h0010]}, 16'h0077);
    chk8("rmid_next_done", 16'(done_cnt - d0), 16'd1);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int d0;
    d0 = done_cnt;
    send_byte(8'h80, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (10) @(negedge clk);
    chk8("csum_ok_err", {15'd0, err}, 16'd0);
    chk8("csum_ok_done", 16'(done_cnt - d0), 16'd1);
    d0 = done_cnt;
    send_byte(8'h80, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (10) @(negedge clk);
    chk8("csum_bad_err", {15'd0, err}, 16'd1);
    chk8("csum_bad_done", 16'(done_cnt - d0), 16'd1);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_len_zero;
    test_wrap;
    test_frame_err;
    test_reset_mid;
`ifdef LOADER_CHECKSUM_EN
    test_checksum;
`endif
    chk8("oe_always_high", 16'(oe_bad), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_serial_loader.md
Name: ram_serial_loader

Overview:
- Serial boot loader sitting directly upstream of the system RAM; drives its Address, data-in and active-low CS/WE/OE lines.
- Receives an 8N1 UART byte stream and parses a frame: start address, length, then payload bytes.
- Writes each payload byte into consecutive RAM locations, giving the CPU a loaded program/data image before it runs.

Parameters:
- AddressSize, 16, RAM address width in bits.
- WordSize, 8, RAM data width in bits; fixed at 8 for the UART byte path.
- ClksPerBit, 16, clk cycles per UART bit; must be >= 4.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  UART serial input; idles high.
- Address  output  AddressSize  RAM address.
- RamData  output  WordSize  data to RAM InData.
- CS  output  1  RAM chip select, active low.
- WE  output  1  RAM write enable, active low.
- OE  output  1  RAM output enable, active low; held high at all times.
- busy  output  1  high from first header byte until frame completion.
- done  output  1  one-cycle pulse on frame completion.
- err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values: CS=1, WE=1, OE=1, Address=0, RamData=0, busy=0, done=0, err=0. Loader FSM returns to HDR_AH; UART receiver returns to idle.
- rx passes through a 2-flop synchroniser before use.
- UART receiver:
  - Falling edge on idle line starts a frame.
  - Line is re-checked at ClksPerBit/2. If high, the start is treated as a glitch and the receiver returns to idle.
  - 8 data bits sampled at mid-bit, LSB first.
  - Stop bit sampled at mid-bit. If 1, the byte is delivered with a one-cycle byte_valid pulse. If 0, framing error: byte discarded and err set.
- Frame format, big-endian 16-bit fields: ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN payload bytes.
- FSM states: HDR_AH -> HDR_AL -> HDR_LH -> HDR_LL -> DATA <-> WRITE -> FIN -> HDR_AH.
- Header states advance one state per byte_valid. busy is set on entering HDR_AL.
- At HDR_LL: if LEN==0, go straight to FIN with no writes. Otherwise go to DATA.
- DATA: on byte_valid, register RamData=byte and Address=cur_addr, and set CS=0, WE=0 → WRITE.
- WRITE lasts exactly one cycle, so RAM samples exactly one posedge with CS/WE low. On exit:
  - CS=1, WE=1.
  - cur_addr increments modulo 2^AddressSize, so 0xFFFF wraps to 0x0000.
  - remaining decrements. If it reaches 0 → FIN, else → DATA.
- Address and RamData hold their values after the write and change only on the next write.
- FIN: done=1 and busy=0 for one cycle, then HDR_AH.
- A new byte cannot arrive during WRITE or FIN, since a byte takes at least 40 cycles.
- Framing error in any state: only the bad byte is dropped. The FSM does not advance, so the next good byte fills the same field.
- Reset mid-frame: takes effect on the next posedge; no further writes occur. Bytes already written remain in RAM.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload byte the FSM enters CHK and consumes one checksum byte.
  - Expected checksum is the 8-bit modulo-256 sum of all payload bytes; it is 0x00 when LEN==0.
  - Mismatch sets err. FIN and the done pulse still occur.
- Undefined: no CHK state; the byte after the payload starts a new frame.

Decomposition:
- Shared package loader_pkg:
  - FSM state enum (HDR_AH, HDR_AL, HDR_LH, HDR_LL, DATA, WRITE, CHK, FIN).
  - Header byte count constant (4).
  - UART idle-level constant.
- One sub-module, uart_byte_rx:
  - Parameter ClksPerBit.
  - Ports clk, reset, rx_sync, byte_out[7:0], byte_valid, frame_err.

Test Plan:
- ClksPerBit=16; bench has a RAM model with async read, posedge write and active-low CS/WE/OE, and checks OE==1 on every cycle.
- Send 0x80 0x00 0x00 0x03 0xAA 0x55 0x01 → Mem[0x8000..0x8002]=AA,55,01; exactly 3 single-cycle WE pulses; one done pulse; busy low afterwards.
- Send 0x12 0x34 0x00 0x00 → done pulses; no WE activity; Mem[0x1234] unchanged.
- Send 0xFF 0xFF 0x00 0x02 0x11 0x22 → Mem[0xFFFF]=0x11, Mem[0x0000]=0x22.
- LEN_HI byte sent with stop bit 0, then a valid 0x00, then 0x01 0x5A → err=1; one write, 0x5A at the given address; done pulses.
- Assert reset for 1 cycle after the first of 3 payload bytes → all outputs at reset values; no further WE. A following frame 0x00 0x10 0x00 0x01 0x77 writes Mem[0x0010]=0x77.
- With LOADER_CHECKSUM_EN, send frame 1 plus checksum 0x00 → err=0, done pulses. Repeat with checksum 0x01 → err=1, done still pulses.
